// File: rtl/switch_port_deb_pkg.sv
// Shared definitions for the switch input port: register map, edge modes, edge filter.
package switch_port_deb_pkg;

    localparam int unsigned BUS_W = 16;

    // Register offsets on the IO bus.
    typedef enum logic [1:0] {
        RegState = 2'd0,
        RegEdge  = 2'd1,
        RegIrqEn = 2'd2,
        RegRaw   = 2'd3
    } sw_reg_e;

    // Edge-mode codes.
    localparam int unsigned SW_EDGE_RISE = 0;
    localparam int unsigned SW_EDGE_FALL = 1;
    localparam int unsigned SW_EDGE_BOTH = 2;

    // True when a debounced transition to new_val should raise a flag under mode.
    function automatic logic edge_match(input int unsigned mode, input logic new_val);
        case (mode)
            SW_EDGE_RISE: return new_val;
            SW_EDGE_FALL: return ~new_val;
            default:      return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/switch_port_deb_if.sv
// IO bus slice seen by the switch port: chip select, strobes, address and data.
interface switch_port_deb_if;
    import switch_port_deb_pkg::*;

    logic             switchaddrcs;
    logic             switchread;
    logic             switchwrite;
    logic [1:0]       switchaddr;
    logic [BUS_W-1:0] switchwdata;
    logic [BUS_W-1:0] switchrdata;

    modport master (
        output switchaddrcs, switchread, switchwrite, switchaddr, switchwdata,
        input  switchrdata
    );

    modport slave (
        input  switchaddrcs, switchread, switchwrite, switchaddr, switchwdata,
        output switchrdata
    );

endinterface

// File: rtl/switch_port_deb_debounce.sv
// One switch channel: 2-FF synchroniser, debounce counter, stable value, edge pulse.
module switch_port_deb_debounce
    import switch_port_deb_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 20000,
    parameter int unsigned EDGE_MODE  = SW_EDGE_RISE
) (
    input  logic switclk,
    input  logic switrst,
    input  logic sw_i,
    output logic raw_s_o,
    output logic stable_o,
    output logic edge_o
);

    localparam int unsigned      CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    // Count consecutive cycles the synced input disagrees with the stable value.
    always_comb begin
        sync1_d  = sw_i;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        accept   = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                accept   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Channel state; reset also discards any partial count.
    always_ff @(posedge switclk or negedge switrst) begin
        if (!switrst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign raw_s_o  = sync2_q;
    assign stable_o = stable_q;
    // Pulse coincides with the edge that updates stable, so the flag lands with STATE.
    assign edge_o   = accept & edge_match(EDGE_MODE, sync2_q);

endmodule

// File: rtl/switch_port_deb.sv
// Memory-mapped debounced switch port: STATE/EDGE/IRQ_EN/RAW registers plus level irq.
module switch_port_deb
    import switch_port_deb_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEB_CYCLES = 20000,
    parameter int unsigned EDGE_MODE  = SW_EDGE_RISE
) (
    input  logic             switclk,
    input  logic             switrst,
    switch_port_deb_if.slave bus,
    input  logic [WIDTH-1:0] switch_i,
    output logic             switch_irq
);

    logic [WIDTH-1:0] raw_s, stable, edge_set, wdata;
    logic [WIDTH-1:0] edge_flags_q, edge_flags_d;
    logic [WIDTH-1:0] irq_en_q, irq_en_d;
    logic             irq_q, irq_d;
    logic [BUS_W-1:0] rdata_q, rdata_d;
    logic             wr_en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        switch_port_deb_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .EDGE_MODE  (EDGE_MODE)
        ) u_deb (
            .switclk  (switclk),
            .switrst  (switrst),
            .sw_i     (switch_i[i]),
            .raw_s_o  (raw_s[i]),
            .stable_o (stable[i]),
            .edge_o   (edge_set[i])
        );
    end

    assign wdata = bus.switchwdata[WIDTH-1:0];

    // Register writes, sticky edge flags and irq next state.
    always_comb begin
        wr_en        = bus.switchaddrcs & bus.switchwrite;
        edge_flags_d = edge_flags_q;
        irq_en_d     = irq_en_q;
        if (wr_en && (sw_reg_e'(bus.switchaddr) == RegEdge)) begin
            edge_flags_d = edge_flags_q & ~wdata;
        end
        if (wr_en && (sw_reg_e'(bus.switchaddr) == RegIrqEn)) begin
            irq_en_d = wdata;
        end
        // A new edge beats a simultaneous clear so no event is lost.
        edge_flags_d = edge_flags_d | edge_set;
        irq_d        = |(edge_flags_q & irq_en_q);
    end

    // Flag, enable and interrupt registers.
    always_ff @(posedge switclk or negedge switrst) begin
        if (!switrst) begin
            edge_flags_q <= '0;
            irq_en_q     <= '0;
            irq_q        <= 1'b0;
        end else begin
            edge_flags_q <= edge_flags_d;
            irq_en_q     <= irq_en_d;
            irq_q        <= irq_d;
        end
    end

    // Read mux; idle bus cycles return zero.
    always_comb begin
        rdata_d = '0;
        if (bus.switchaddrcs && bus.switchread) begin
            case (sw_reg_e'(bus.switchaddr))
                RegState: rdata_d = BUS_W'(stable);
                RegEdge:  rdata_d = BUS_W'(edge_flags_q);
                RegIrqEn: rdata_d = BUS_W'(irq_en_q);
                RegRaw:   rdata_d = BUS_W'(raw_s);
            endcase
        end
    end

    // Read data on the falling edge, ahead of any write at the next rising edge.
    always_ff @(negedge switclk or negedge switrst) begin
        if (!switrst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign bus.switchrdata = rdata_q;
    assign switch_irq      = irq_q;

endmodule

// File: tb/tb_switch_port_deb.sv
// Bench for switch_port_deb: three instances (rise/16, both/16, fall/10) share stimulus
// and are compared every cycle against a behavioural model.
module tb_switch_port_deb;
    import switch_port_deb_pkg::*;

    localparam int unsigned DEB = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sw    = 16'h0;
    logic [2:0]  irq_w;

    always #5 clk = ~clk;

    switch_port_deb_if bus0 ();
    switch_port_deb_if bus1 ();
    switch_port_deb_if bus2 ();

    switch_port_deb #(.WIDTH(16), .DEB_CYCLES(DEB), .EDGE_MODE(SW_EDGE_RISE)) u_dut_rise (
        .switclk (clk), .switrst (rst_n), .bus (bus0), .switch_i (sw), .switch_irq (irq_w[0])
    );
    switch_port_deb #(.WIDTH(16), .DEB_CYCLES(DEB), .EDGE_MODE(SW_EDGE_BOTH)) u_dut_both (
        .switclk (clk), .switrst (rst_n), .bus (bus1), .switch_i (sw), .switch_irq (irq_w[1])
    );
    switch_port_deb #(.WIDTH(10), .DEB_CYCLES(DEB), .EDGE_MODE(SW_EDGE_FALL)) u_dut_w10 (
        .switclk (clk), .switrst (rst_n), .bus (bus2), .switch_i (sw[9:0]),
        .switch_irq (irq_w[2])
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Behavioural model state.
    logic [15:0] hist [$];
    logic [15:0] m_st  [3] = '{default: 16'h0};
    logic [15:0] m_ed  [3] = '{default: 16'h0};
    logic [15:0] m_en  [3] = '{default: 16'h0};
    logic [15:0] m_raw [3] = '{default: 16'h0};
    logic        m_irq [3] = '{default: 1'b0};
    int          run   [3][16];

    logic [15:0] last_rd  [3];
    logic        last_irq [3];

    function automatic int wid_of(input int k);
        return (k == 2) ? 10 : 16;
    endfunction

    function automatic int unsigned mode_of(input int k);
        case (k)
            0:       return SW_EDGE_RISE;
            1:       return SW_EDGE_BOTH;
            default: return SW_EDGE_FALL;
        endcase
    endfunction

    function automatic logic [15:0] mask_of(input int k);
        return (k == 2) ? 16'h03FF : 16'hFFFF;
    endfunction

    function automatic logic [15:0] mreg(input int k, input logic [1:0] a);
        case (a)
            2'd0:    return m_st[k];
            2'd1:    return m_ed[k];
            2'd2:    return m_en[k];
            default: return m_raw[k];
        endcase
    endfunction

    function automatic logic [15:0] obs_rd(input int k);
        case (k)
            0:       return bus0.switchrdata;
            1:       return bus1.switchrdata;
            default: return bus2.switchrdata;
        endcase
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < 3; k++) begin
            m_st[k] = 16'h0; m_ed[k] = 16'h0; m_en[k] = 16'h0; m_raw[k] = 16'h0;
            m_irq[k] = 1'b0;
            for (int i = 0; i < 16; i++) run[k][i] = 0;
        end
    endtask

    // One rising clock edge of the model: inputs reach the debouncer two samples late,
    // a value is accepted after DEB consecutive disagreeing samples.
    task automatic model_step();
        logic [15:0] raw_before, clr, pulse;
        logic        irq_next;
        logic        wr;
        if (!rst_n) begin
            model_reset();
            return;
        end
        raw_before = (hist.size() >= 2) ? hist[1] : 16'h0;
        hist.push_front(sw);
        if (hist.size() > 3) void'(hist.pop_back());
        wr  = bus0.switchaddrcs && bus0.switchwrite;
        clr = (wr && bus0.switchaddr == 2'd1) ? bus0.switchwdata : 16'h0;
        for (int k = 0; k < 3; k++) begin
            pulse = 16'h0;
            for (int i = 0; i < wid_of(k); i++) begin
                if (raw_before[i] != m_st[k][i]) begin
                    run[k][i]++;
                    if (run[k][i] == int'(DEB)) begin
                        m_st[k][i] = raw_before[i];
                        run[k][i]  = 0;
                        if (mode_of(k) == SW_EDGE_BOTH ||
                            (mode_of(k) == SW_EDGE_RISE && raw_before[i]) ||
                            (mode_of(k) == SW_EDGE_FALL && !raw_before[i]))
                            pulse[i] = 1'b1;
                    end
                end else begin
                    run[k][i] = 0;
                end
            end
            irq_next = |(m_ed[k] & m_en[k]);
            m_ed[k]  = (m_ed[k] & ~clr) | pulse;
            if (wr && bus0.switchaddr == 2'd2) m_en[k] = bus0.switchwdata & mask_of(k);
            m_irq[k] = irq_next;
            m_raw[k] = ((hist.size() >= 2) ? hist[1] : 16'h0) & mask_of(k);
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_bus(input logic cs, input logic rd, input logic wr,
                             input logic [1:0] a, input logic [15:0] wd);
        bus0.switchaddrcs = cs; bus0.switchread = rd; bus0.switchwrite = wr;
        bus0.switchaddr = a; bus0.switchwdata = wd;
        bus1.switchaddrcs = cs; bus1.switchread = rd; bus1.switchwrite = wr;
        bus1.switchaddr = a; bus1.switchwdata = wd;
        bus2.switchaddrcs = cs; bus2.switchread = rd; bus2.switchwrite = wr;
        bus2.switchaddr = a; bus2.switchwdata = wd;
    endtask

    // One bus cycle starting just after a rising edge: check read data and irq of every
    // instance at the falling edge, then step the model on the next rising edge.
    task automatic bus_cycle(input logic cs, input logic rd, input logic wr,
                             input logic [1:0] a, input logic [15:0] wd, input string tag);
        logic [15:0] exp;
        drive_bus(cs, rd, wr, a, wd);
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            exp         = (cs && rd) ? mreg(k, a) : 16'h0;
            last_rd[k]  = obs_rd(k);
            last_irq[k] = irq_w[k];
            chk($sformatf("%s_rd%0d", tag, k), last_rd[k], exp);
            chk($sformatf("%s_irq%0d", tag, k), {15'b0, irq_w[k]}, {15'b0, m_irq[k]});
        end
        @(posedge clk);
        model_step();
        #2;
        drive_bus(1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) bus_cycle(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, "idle");
    endtask

    task automatic rd(input logic [1:0] a, input string tag);
        bus_cycle(1'b1, 1'b1, 1'b0, a, 16'h0, tag);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d, input string tag);
        bus_cycle(1'b1, 1'b0, 1'b1, a, d, tag);
    endtask

    initial begin
        drive_bus(1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
        model_reset();
        @(posedge clk);
        #2;
        idle(2);
        chk("rst_irq", {15'b0, irq_w[0]}, 16'h0);
        rst_n = 1'b1;

        // Bit 3 rises; RAW follows after two edges, then reset lands mid-count.
        sw[3] = 1'b1;
        idle(1);
        rd(RegRaw, "raw_e1");
        chk("raw_after1", last_rd[0], 16'h0000);
        rd(RegRaw, "raw_e2");
        chk("raw_after2", last_rd[0], 16'h0008);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_async_rd", bus0.switchrdata, 16'h0000);
        chk("rst_async_irq", {15'b0, irq_w[0]}, 16'h0);
        idle(1);
        rst_n = 1'b1;
        idle(4);
        rd(RegState, "st_e4");
        rd(RegState, "st_e5");
        chk("state_before6", last_rd[0], 16'h0000);
        rd(RegState, "st_e6");
        chk("state_at6", last_rd[0], 16'h0008);

        // Three-cycle glitch on bit 0 is rejected.
        wr(RegEdge, 16'hFFFF, "clr_all");
        wr(RegIrqEn, 16'h0008, "en3");
        rd(RegIrqEn, "en_rb");
        chk("irqen_w10", last_rd[2], 16'h0008);
        sw[0] = 1'b1;
        idle(3);
        sw[0] = 1'b0;
        for (int n = 0; n < 8; n++) rd(RegState, "glitch_st");
        chk("glitch_state", last_rd[0], 16'h0008);
        rd(RegEdge, "glitch_ed");
        chk("glitch_edge", last_rd[0], 16'h0000);

        // Rising edge sets EDGE, irq follows a cycle later; W1C drops it again.
        sw[3] = 1'b0;
        idle(8);
        wr(RegEdge, 16'hFFFF, "clr_fall");
        sw[3] = 1'b1;
        idle(4);
        rd(RegEdge, "rise_e4");
        rd(RegEdge, "rise_e5");
        chk("edge_before", last_rd[0], 16'h0000);
        rd(RegEdge, "rise_e6");
        chk("edge_set", last_rd[0], 16'h0008);
        chk("irq_same", {15'b0, last_irq[0]}, 16'h0);
        bus_cycle(1'b1, 1'b1, 1'b1, RegEdge, 16'h0008, "w1c_rw");
        chk("rw_pre", last_rd[0], 16'h0008);
        chk("irq_next", {15'b0, last_irq[0]}, 16'h1);
        rd(RegEdge, "after_w1c");
        chk("edge_clr", last_rd[0], 16'h0000);
        chk("irq_hold", {15'b0, last_irq[0]}, 16'h1);
        rd(RegEdge, "irq_drop");
        chk("irq_clr", {15'b0, last_irq[0]}, 16'h0);

        // Both-edge mode on bit 5 with a clear landing on the same edge as the event.
        wr(RegEdge, 16'hFFFF, "clr5");
        sw[5] = 1'b1;
        idle(5);
        wr(RegEdge, 16'h0020, "w1c_rise");
        rd(RegEdge, "both_rise");
        chk("both_rise_kept", last_rd[1] & 16'h0020, 16'h0020);
        wr(RegEdge, 16'h0020, "clr_b5");
        sw[5] = 1'b0;
        idle(5);
        wr(RegEdge, 16'h0020, "w1c_fall");
        rd(RegEdge, "both_fall");
        chk("both_fall_kept", last_rd[1] & 16'h0020, 16'h0020);
        chk("rise_no_fall", last_rd[0] & 16'h0020, 16'h0000);
        chk("fall_mode_set", last_rd[2] & 16'h0020, 16'h0020);

        // All inputs high; narrow instance zero-extends; no chip select reads zero.
        sw = 16'hFFFF;
        idle(8);
        rd(RegState, "all_hi");
        chk("w10_state", last_rd[2], 16'h03FF);
        chk("w16_state", last_rd[0], 16'hFFFF);
        bus_cycle(1'b0, 1'b1, 1'b0, RegState, 16'h0, "cs_low");
        chk("cs_low_rd", last_rd[2], 16'h0000);

        // Randomised traffic: toggles (some short enough to be glitches) and bus ops.
        for (int n = 0; n < 600; n++) begin
            logic        cs, rdv, wrv;
            logic [1:0]  a;
            logic [15:0] wd;
            if ($urandom_range(0, 2) == 0) sw[$urandom_range(0, 5)] ^= 1'b1;
            if ($urandom_range(0, 19) == 0) sw[$urandom_range(0, 15)] ^= 1'b1;
            cs  = ($urandom_range(0, 7) != 0);
            rdv = 1'($urandom_range(0, 1));
            wrv = ($urandom_range(0, 5) == 0);
            a   = 2'($urandom_range(0, 3));
            wd  = 16'($urandom);
            bus_cycle(cs, rdv, wrv, a, wd, "rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
